// File: rtl/palette_write_sched.sv
// Palette RAM write-port sequencer: clears all 16 entries after reset, then
// commits queued CPU palette writes in order, one per cycle, while blanking.
module palette_write_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter bit BLANK_ONLY = 1'b1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cpu_valid,
  output logic                             cpu_ready,
  input  logic [3:0]                       cpu_addr,
  input  logic [7:0]                       cpu_data,
  input  logic                             blank,
  output logic                             pal_we,
  output logic [3:0]                       pal_addr_wr,
  output logic [7:0]                       pal_data_in,
  output logic                             init_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  pending
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e                       state_q, state_d;
  logic [3:0]                   clr_idx_q, clr_idx_d;
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                pending_q, pending_d;
  logic [FIFO_DEPTH-1:0][11:0]  mem_q, mem_d;
  logic                         we_q, we_d;
  logic [3:0]                   addr_q, addr_d;
  logic [7:0]                   data_q, data_d;
  logic                         done_q, done_d;
  logic                         push, pop;

  // Fullness is judged on the current occupancy only; a same-edge pop does not free a slot.
  assign cpu_ready   = !reset && (pending_q < CW'(FIFO_DEPTH));
  assign pal_we      = we_q;
  assign pal_addr_wr = addr_q;
  assign pal_data_in = data_q;
  assign init_done   = done_q;
  assign pending     = pending_q;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_d     = mem_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    done_d    = done_q;
    pop       = 1'b0;
    push      = cpu_valid && cpu_ready;

    if (push) begin
      mem_d[wr_ptr_q] = {cpu_addr, cpu_data};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    case (state_q)
      CLEAR: begin
        we_d      = 1'b1;
        addr_d    = clr_idx_q;
        data_d    = 8'h00;
        clr_idx_d = clr_idx_q + 4'd1;
        if (clr_idx_q == 4'd15) state_d = RUN;
      end
      default: begin
        done_d = 1'b1;
        // Head is read from mem_q, so a same-edge push never bypasses into the pop.
        if ((pending_q != '0) && (blank || !BLANK_ONLY)) begin
          pop              = 1'b1;
          we_d             = 1'b1;
          {addr_d, data_d} = mem_q[rd_ptr_q];
          rd_ptr_d         = rd_ptr_q + PW'(1);
        end
      end
    endcase

    pending_d = pending_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= 4'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pending_q <= '0;
      we_q      <= 1'b0;
      addr_q    <= 4'd0;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pending_q <= pending_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
